// File: rtl/riscv_pkg.sv
// Shared load/store encodings, FSM state type and access-size helpers for the
// memory-access stage.
package riscv_pkg;

  // FUNCT3 encodings for loads and stores.
  localparam logic [2:0] Funct3B  = 3'b000;
  localparam logic [2:0] Funct3H  = 3'b001;
  localparam logic [2:0] Funct3W  = 3'b010;
  localparam logic [2:0] Funct3Bu = 3'b100;
  localparam logic [2:0] Funct3Hu = 3'b101;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } mem_state_e;

  typedef enum logic [1:0] {
    SizeByte,
    SizeHalf,
    SizeWord
  } access_size_e;

  // Reserved encodings fall through to word size.
  function automatic access_size_e access_size(input logic [2:0] funct3);
    case (funct3)
      Funct3B, Funct3Bu: access_size = SizeByte;
      Funct3H, Funct3Hu: access_size = SizeHalf;
      default:           access_size = SizeWord;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (access_size(funct3))
      SizeHalf: is_misaligned = addr_lo[0];
      SizeWord: is_misaligned = (addr_lo != 2'b00);
      default:  is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select and sign/zero extension of a 32-bit memory read word.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed byte/half and extend it to 32 bits.
  always_comb begin
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      Funct3B:  data = {{24{byte_lane[7]}}, byte_lane};
      Funct3H:  data = {{16{half_lane[15]}}, half_lane};
      Funct3Bu: data = {24'h000000, byte_lane};
      Funct3Hu: data = {16'h0000, half_lane};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues one load/store at a time to a simple
// req/ack memory port, stalls upstream while busy, and produces a one-cycle
// writeback pulse for ALU results and completed loads.
// Optional build macro MEM_ACCESS_MISALIGN_TRAP_EN: misaligned half/word
// accesses are refused and flagged on MISALIGN instead of being issued.
module mem_access
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32  // only 32 is supported
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] store_data,
  input  logic [2:0]      funct3,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [4:0]      rd_in,
  output logic            stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            misalign
);

  mem_state_e state_q, state_d;

  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] sdata_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic            store_q;

  logic            is_mem_op;
  logic            accept;
  logic            alu_wb;
  logic            load_done;
  logic [XLEN-1:0] load_data;

  logic            wb_valid_q;
  logic [XLEN-1:0] wb_data_q;
  logic [4:0]      wb_rd_q;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic trap;
  logic misalign_q;
`endif

  // Next-state logic and completion decode.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    trap      = 1'b0;
`endif
    is_mem_op = valid_in && (mem_read || mem_write);
    case (state_q)
      StIdle: begin
        if (is_mem_op) begin
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
          if (is_misaligned(funct3, alu_result[1:0])) begin
            trap = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = StBusy;
          end
`else
          accept  = 1'b1;
          state_d = StBusy;
`endif
        end
      end
      StBusy: begin
        if (mem_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Non-memory ops only retire from IDLE; BUSY ignores valid_in.
    alu_wb    = (state_q == StIdle) && valid_in && !mem_read && !mem_write;
    load_done = (state_q == StBusy) && mem_ack && !store_q;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the accepted access; read+write together is treated as a store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      sdata_q  <= '0;
      funct3_q <= 3'b000;
      rd_q     <= 5'd0;
      store_q  <= 1'b0;
    end else if (accept) begin
      addr_q   <= alu_result;
      sdata_q  <= store_data;
      funct3_q <= funct3;
      rd_q     <= rd_in;
      store_q  <= mem_write;
    end
  end

  // Memory port drive: zero whenever idle so reset clears it immediately.
  always_comb begin
    stall     = (state_q == StBusy);
    mem_req   = (state_q == StBusy);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = 4'b0000;
    if (state_q == StBusy) begin
      mem_addr = {addr_q[XLEN-1:2], 2'b00};
      if (store_q) begin
        mem_we = 1'b1;
        case (access_size(funct3_q))
          SizeByte: begin
            mem_wdata = {4{sdata_q[7:0]}};
            mem_be    = 4'b0001 << addr_q[1:0];
          end
          SizeHalf: begin
            mem_wdata = {2{sdata_q[15:0]}};
            mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
          end
          default: begin
            mem_wdata = sdata_q;
            mem_be    = 4'b1111;
          end
        endcase
      end
    end
  end

  load_align u_load_align (
    .rdata   (mem_rdata),
    .funct3  (funct3_q),
    .addr_lo (addr_q[1:0]),
    .data    (load_data)
  );

  // Writeback bundle: one-cycle pulse, data/rd held between pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= 5'd0;
    end else begin
      wb_valid_q <= 1'b0;
      if (alu_wb) begin
        wb_valid_q <= 1'b1;
        wb_data_q  <= alu_result;
        wb_rd_q    <= rd_in;
      end else if (load_done) begin
        wb_valid_q <= 1'b1;
        wb_data_q  <= load_data;
        wb_rd_q    <= rd_q;
      end
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_data_q;
  assign wb_rd    = wb_rd_q;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  // One-cycle flag for a refused misaligned access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= trap;
    end
  end
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

endmodule
